// File: rtl/median_window_feeder.sv
// rtl/median_window_feeder.sv - 3x3 window burst driver for the MEDIAN filter
module median_window_feeder #(
    parameter int IMG_W   = 16,
    parameter int PIX_W   = 8,
    parameter int TIMEOUT = 64
) (
    input  logic             CLK,
    input  logic             nRST,
    input  logic [PIX_W-1:0] PI,
    input  logic             PI_VALID,
    input  logic             PI_SOF,
    output logic             PI_READY,
    output logic [PIX_W-1:0] DI,
    output logic             DSI,
    input  logic [PIX_W-1:0] DO,
    input  logic             DSO,
    output logic [PIX_W-1:0] PO,
    output logic             PO_VALID,
    output logic             ERR
);
    localparam int COL_W = $clog2(IMG_W);
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_BURST, S_WAIT} state_t;

    state_t           state_q, state_d;
    logic [1:0]       row_q, row_d;
    logic             row_ok_q, row_ok_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [1:0]       win_row_q, win_row_d;
    logic [COL_W-1:0] win_col_q, win_col_d;
    logic [3:0]       idx_q, idx_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [PIX_W-1:0] di_q, di_d;
    logic [PIX_W-1:0] po_q, po_d;
    logic             dsi_q, dsi_d;
    logic             po_valid_q, po_valid_d;
    logic             err_q, err_d;

    logic [PIX_W-1:0] line_mem_q [3][IMG_W];

    logic             accept;
    logic [1:0]       cur_row;
    logic [COL_W-1:0] cur_col;
    logic             cur_ok;
    logic [3:0]       rd_k;
    logic [1:0]       base_row;
    logic [COL_W-1:0] base_col;
    logic [1:0]       rd_back;
    logic [1:0]       rd_off;
    logic [1:0]       rd_row;
    logic [COL_W-1:0] rd_col;
    logic [PIX_W-1:0] rd_pix;

    assign PI_READY = (state_q == S_IDLE) & nRST;
    assign accept   = PI_VALID & PI_READY;
    assign DI       = di_q;
    assign DSI      = dsi_q;
    assign PO       = po_q;
    assign PO_VALID = po_valid_q;
    assign ERR      = err_q;

    // A start-of-frame pixel is placed at (0,0) regardless of the running counters.
    always_comb begin
        cur_row = PI_SOF ? 2'd0 : row_q;
        cur_col = PI_SOF ? '0 : col_q;
        cur_ok  = PI_SOF ? 1'b0 : row_ok_q;
    end

    // Window element k lives (2 - k/3) rows back from the newest row, column offset k%3.
    always_comb begin
        rd_k     = 4'd0;
        base_row = cur_row;
        base_col = cur_col - COL_W'(2);
        if (state_q == S_BURST) begin
            rd_k     = idx_q + 4'd1;
            base_row = win_row_q;
            base_col = win_col_q;
        end
        case (rd_k)
            4'd0, 4'd1, 4'd2: rd_back = 2'd2;
            4'd3, 4'd4, 4'd5: rd_back = 2'd1;
            default:          rd_back = 2'd0;
        endcase
        case (rd_k)
            4'd0, 4'd3, 4'd6: rd_off = 2'd0;
            4'd1, 4'd4, 4'd7: rd_off = 2'd1;
            default:          rd_off = 2'd2;
        endcase
        case (rd_back)
            2'd1:    rd_row = (base_row == 2'd0) ? 2'd2 : base_row - 2'd1;
            2'd2:    rd_row = (base_row == 2'd2) ? 2'd0 : base_row + 2'd1;
            default: rd_row = base_row;
        endcase
        rd_col = base_col + COL_W'(rd_off);
        rd_pix = line_mem_q[rd_row][rd_col];
    end

    always_comb begin
        state_d    = state_q;
        row_d      = row_q;
        row_ok_d   = row_ok_q;
        col_d      = col_q;
        win_row_d  = win_row_q;
        win_col_d  = win_col_q;
        idx_d      = idx_q;
        tmo_d      = tmo_q;
        di_d       = di_q;
        dsi_d      = 1'b0;
        po_d       = po_q;
        po_valid_d = 1'b0;
        err_d      = err_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (cur_col == COL_W'(IMG_W - 1)) begin
                        col_d    = '0;
                        row_d    = (cur_row == 2'd2) ? 2'd0 : cur_row + 2'd1;
                        row_ok_d = cur_ok | (cur_row == 2'd1);
                    end else begin
                        col_d    = cur_col + COL_W'(1);
                        row_d    = cur_row;
                        row_ok_d = cur_ok;
                    end
                    if (cur_ok && (cur_col >= COL_W'(2))) begin
                        state_d   = S_BURST;
                        idx_d     = 4'd0;
                        dsi_d     = 1'b1;
                        di_d      = rd_pix;
                        win_row_d = cur_row;
                        win_col_d = cur_col - COL_W'(2);
                    end
                end
            end
            S_BURST: begin
                if (idx_q == 4'd8) begin
                    state_d = S_WAIT;
                    tmo_d   = '0;
                end else begin
                    dsi_d = 1'b1;
                    di_d  = rd_pix;
                    idx_d = idx_q + 4'd1;
                end
            end
            S_WAIT: begin
                if (DSO) begin
                    po_d       = DO;
                    po_valid_d = 1'b1;
                    state_d    = S_IDLE;
                end else if (tmo_q == TMO_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_q    <= S_IDLE;
            row_q      <= 2'd0;
            row_ok_q   <= 1'b0;
            col_q      <= '0;
            win_row_q  <= 2'd0;
            win_col_q  <= '0;
            idx_q      <= 4'd0;
            tmo_q      <= '0;
            di_q       <= '0;
            dsi_q      <= 1'b0;
            po_q       <= '0;
            po_valid_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            row_q      <= row_d;
            row_ok_q   <= row_ok_d;
            col_q      <= col_d;
            win_row_q  <= win_row_d;
            win_col_q  <= win_col_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            di_q       <= di_d;
            dsi_q      <= dsi_d;
            po_q       <= po_d;
            po_valid_q <= po_valid_d;
            err_q      <= err_d;
        end
    end

    // Line storage needs no reset: rows are only read once row_ok proves them written.
    always_ff @(posedge CLK) begin
        if (accept) begin
            line_mem_q[cur_row][cur_col] <= PI;
        end
    end
endmodule

// File: tb/tb_median_window_feeder.sv
// tb/tb_median_window_feeder.sv - random and directed checks of median_window_feeder
module tb_median_window_feeder;
    localparam int W   = 16;
    localparam int TMO = 64;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       nrst;
    logic [7:0] pi, di, do_in, po;
    logic       pi_valid, pi_sof, pi_ready, dsi, dso, po_valid, err;

    logic [7:0] pi4, di4, do4, po4;
    logic       pv4, ps4, pr4, dsi4, dso4, pov4, err4;

    median_window_feeder #(.IMG_W(W), .PIX_W(8), .TIMEOUT(TMO)) dut (
        .CLK(clk), .nRST(nrst), .PI(pi), .PI_VALID(pi_valid), .PI_SOF(pi_sof),
        .PI_READY(pi_ready), .DI(di), .DSI(dsi), .DO(do_in), .DSO(dso),
        .PO(po), .PO_VALID(po_valid), .ERR(err)
    );

    median_window_feeder #(.IMG_W(4), .PIX_W(8), .TIMEOUT(TMO)) dut4 (
        .CLK(clk), .nRST(nrst), .PI(pi4), .PI_VALID(pv4), .PI_SOF(ps4),
        .PI_READY(pr4), .DI(di4), .DSI(dsi4), .DO(do4), .DSO(dso4),
        .PO(po4), .PO_VALID(pov4), .ERR(err4)
    );

    int vectors = 0;
    int miscompares = 0;

    int  img [64][W];
    int  mr = 0, mc = 0;
    int  left = 0, pending = 0, wcnt = 0;
    bit  exp_err = 0, exp_pov = 0;
    int  exp_po = 0;
    int  win [9];
    int  med_q [$];
    bit  chk_en = 0;
    int  po_count = 0;
    bit  withhold = 0;
    int  b4_q [$];
    int  po4_q [$];

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int med9(input int v [9]);
        int a [9];
        int t;
        a = v;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8 - i; j++)
                if (a[j] > a[j+1]) begin
                    t = a[j]; a[j] = a[j+1]; a[j+1] = t;
                end
        return a[4];
    endfunction

    task automatic model_accept(input int p, input bit sof);
        if (sof) begin mr = 0; mc = 0; end
        img[mr % 64][mc] = p;
        if (mr >= 2 && mc >= 2) begin
            for (int k = 0; k < 9; k++) win[k] = img[(mr - 2 + k / 3) % 64][mc - 2 + k % 3];
            med_q.push_back(med9(win));
            left = 9;
        end
        mc++;
        if (mc == W) begin mc = 0; mr++; end
    endtask

    // Cycle-by-cycle comparison of the main instance against the window model.
    initial begin
        bit busy;
        forever begin
            @(negedge clk);
            if (chk_en) begin
                busy = (left > 0) || (pending != 0);
                check("pi_ready", int'(pi_ready), int'(!busy && nrst));
                check("dsi", int'(dsi), int'(left > 0));
                if (left > 0) check("di", int'(di), win[9 - left]);
                check("po_valid", int'(po_valid), int'(exp_pov));
                if (exp_pov) check("po", int'(po), exp_po);
                check("err", int'(err), int'(exp_err));
                if (po_valid) po_count++;
                exp_pov = 0;
                if (!nrst) begin
                    left = 0; pending = 0; exp_err = 0; mr = 0; mc = 0;
                    med_q.delete();
                end else begin
                    if (left > 0) begin
                        left--;
                        if (left == 0) begin pending = 1; wcnt = 0; end
                    end else if (pending != 0) begin
                        if (dso) begin
                            exp_pov = 1; exp_po = med_q.pop_front(); pending = 0;
                        end else begin
                            wcnt++;
                            if (wcnt == TMO) begin
                                exp_err = 1; pending = 0; void'(med_q.pop_front());
                            end
                        end
                    end
                    if (!busy && pi_valid) model_accept(int'(pi), pi_sof);
                end
            end
        end
    end

    // Behavioural MEDIAN for the main instance, random result latency.
    initial begin
        int coll [9];
        int n;
        int lat;
        n = 0; dso = 1'b0; do_in = 8'd0;
        forever begin
            @(negedge clk);
            if (!nrst) n = 0;
            else if (dsi) begin
                coll[n] = int'(di); n++;
                if (n == 9) begin
                    n = 0;
                    if (!withhold) begin
                        lat = $urandom_range(1, 4);
                        repeat (lat) @(posedge clk);
                        #1;
                        if (nrst) begin
                            do_in = 8'(med9(coll)); dso = 1'b1;
                            @(posedge clk); #1;
                            dso = 1'b0; do_in = 8'($urandom);
                        end
                    end
                end
            end
        end
    end

    // Behavioural MEDIAN for the narrow instance, fixed latency, records bursts and results.
    initial begin
        int c4 [9];
        int n4;
        n4 = 0; dso4 = 1'b0; do4 = 8'd0;
        forever begin
            @(negedge clk);
            if (!nrst) n4 = 0;
            else begin
                if (pov4) po4_q.push_back(int'(po4));
                if (dsi4) begin
                    c4[n4] = int'(di4); b4_q.push_back(int'(di4)); n4++;
                    if (n4 == 9) begin
                        n4 = 0;
                        repeat (2) @(posedge clk);
                        #1; do4 = 8'(med9(c4)); dso4 = 1'b1;
                        @(posedge clk); #1; dso4 = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send(input logic [7:0] p, input bit sof);
        int n;
        n = 0;
        repeat ($urandom_range(0, 2)) begin @(posedge clk); #2; end
        pi = p; pi_sof = sof; pi_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (pi_ready) break;
            n++;
            if (n > 500) begin
                vectors++; miscompares++;
                $display("FAIL send_timeout: got ready=0 expected ready=1");
                break;
            end
        end
        @(posedge clk); #2;
        pi_valid = 1'b0; pi_sof = 1'b0; pi = 8'($urandom);
    endtask

    task automatic send4(input logic [7:0] p, input bit sof);
        int n;
        n = 0;
        pi4 = p; ps4 = sof; pv4 = 1'b1;
        forever begin
            @(negedge clk);
            if (pr4) break;
            n++;
            if (n > 500) begin
                vectors++; miscompares++;
                $display("FAIL send4_timeout: got ready=0 expected ready=1");
                break;
            end
        end
        @(posedge clk); #2;
        pv4 = 1'b0; ps4 = 1'b0;
    endtask

    task automatic frame(input int rows, input int extra);
        for (int i = 0; i < rows * W + extra; i++) send(8'($urandom), i == 0);
    endtask

    task automatic settle();
        repeat (30) @(posedge clk);
        #2;
    endtask

    initial begin
        int t2_b [18];
        int base;
        t2_b = '{0, 1, 2, 4, 5, 6, 8, 9, 10, 1, 2, 3, 5, 6, 7, 9, 10, 11};
        nrst = 1'b0; pi = 8'd0; pi_valid = 1'b0; pi_sof = 1'b0;
        pi4 = 8'd0; pv4 = 1'b0; ps4 = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check("rst_dsi", int'(dsi), 0);
        check("rst_po_valid", int'(po_valid), 0);
        check("rst_err", int'(err), 0);
        check("rst_ready", int'(pi_ready), 0);
        check("rst_po", int'(po), 0);
        chk_en = 1; nrst = 1'b1;
        @(negedge clk);
        check("ready_after_rst", int'(pi_ready), 1);
        @(posedge clk); #2;

        // Ramp through the 4-wide instance.
        for (int i = 0; i < 12; i++) send4(8'(i), i == 0);
        repeat (40) @(posedge clk);
        #2;
        check("t2_po_count", po4_q.size(), 2);
        check("t2_burst_len", b4_q.size(), 18);
        for (int i = 0; i < 2; i++) check("t2_po", (i < po4_q.size()) ? po4_q[i] : -1, 5 + i);
        for (int i = 0; i < 18; i++) check("t2_burst", (i < b4_q.size()) ? b4_q[i] : -1, t2_b[i]);

        // Random full frames.
        for (int f = 0; f < 2; f++) begin
            base = po_count;
            frame(20, 0);
            settle();
            check("t3_outputs", po_count - base, 18 * (W - 2));
        end

        // Withheld result: timeout, sticky error.
        base = po_count;
        withhold = 1;
        frame(2, 3);
        repeat (80) @(posedge clk);
        #2;
        check("t4_err", int'(err), 1);
        check("t4_no_po", po_count - base, 0);
        withhold = 0;
        for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0);
        settle();
        check("t4_err_sticky", int'(err), 1);
        check("t4_later_po", po_count - base, 3);
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        nrst = 1'b1;
        check("t4_err_cleared", int'(err), 0);

        // Reset in the middle of a burst.
        base = po_count;
        frame(2, 3);
        repeat (4) @(posedge clk);
        #2;
        nrst = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        nrst = 1'b1;
        settle();
        check("t5_no_po", po_count - base, 0);
        base = po_count;
        frame(4, 0);
        settle();
        check("t5_outputs", po_count - base, 2 * (W - 2));

        // Start of frame in the middle of row 3.
        base = po_count;
        frame(3, 7);
        frame(4, 0);
        settle();
        check("t6_outputs", po_count - base, (W - 2) + 5 + 2 * (W - 2));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
